mem_ctrl: RTL

Memory controller that shares the CPU's single byte-wide RAM port between instruction fetch (IF) and load/store (MEM). It serialises each 1/2/4-byte access into consecutive byte cycles and assembles or splits little-endian words. It raises per-port stall requests toward `ctrl` so that `pc_reg` and the pipeline hold while an access is in flight.

---
 rtl/mem_ctrl_pkg.sv | 41 ++++
 rtl/mem_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encoding and byte helpers for the byte-serial
// memory controller.
package mem_ctrl_pkg;

  // Access size codes carried on mem_len_i (2'b11 behaves as a word)
  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  // Width of one RAM data beat
  localparam int RamByteW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IF_RD  = 2'b01,
    MEM_RD = 2'b10,
    MEM_WR = 2'b11
  } state_e;

  // Number of byte beats for an access size code
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      LenByte: return 3'd1;
      LenHalf: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Little-endian byte lane idx of a 32-bit word
  function automatic logic [RamByteW-1:0] byte_sel(input logic [31:0] w,
                                                   input logic [2:0]  idx);
    case (idx)
      3'd0:    return w[7:0];
      3'd1:    return w[15:8];
      3'd2:    return w[23:16];
      3'd3:    return w[31:24];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port shared between instruction fetch and load/store.
// MEM wins arbitration; a finishing transaction may hand the port straight
// to the other requester at its last edge.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_len_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic                  stallreq_if_o,
  output logic                  stallreq_mem_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [RamByteW-1:0]   ram_dout_o,
  input  logic [RamByteW-1:0]   ram_din_i
);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            len_n_q, len_n_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_we_q, ram_we_d;
  logic [RamByteW-1:0]   ram_dout_q, ram_dout_d;
  logic                  if_done_q, if_done_d;
  logic                  mem_done_q, mem_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;

  logic [2:0]            cnt_inc_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [31:0]           acc_next_s;
  logic                  finish_s;
  logic                  free_s;
  logic                  take_mem_s;
  logic                  take_if_s;

  // Arbitration: a port is eligible when the FSM is idle or on its last edge,
  // never while its own done is showing and never to restart itself
  always_comb begin
    cnt_inc_s   = cnt_q + 3'd1;
    next_addr_s = base_q + ADDR_WIDTH'(cnt_inc_s);
    case (state_q)
      IF_RD, MEM_RD: finish_s = (cnt_q == len_n_q);
      MEM_WR:        finish_s = (cnt_inc_s == len_n_q);
      default:       finish_s = 1'b0;
    endcase
    free_s     = (state_q == IDLE) | finish_s;
    take_mem_s = free_s & mem_req_i & ~mem_done_q & ~(finish_s & (state_q != IF_RD));
    take_if_s  = free_s & if_req_i & ~if_done_q & ~(finish_s & (state_q == IF_RD))
                 & ~take_mem_s;
  end

  // Place the byte returned for beat cnt_q-1 into the assembly word
  always_comb begin
    acc_next_s = acc_q;
    case (cnt_q)
      3'd1:    acc_next_s[7:0]   = ram_din_i;
      3'd2:    acc_next_s[15:8]  = ram_din_i;
      3'd3:    acc_next_s[23:16] = ram_din_i;
      3'd4:    acc_next_s[31:24] = ram_din_i;
      default: acc_next_s        = acc_q;
    endcase
  end

  // Next-state and next-output logic for the byte sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_n_d     = len_n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    acc_d       = acc_q;
    ram_addr_d  = '0;
    ram_we_d    = 1'b0;
    ram_dout_d  = 8'h00;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = 32'h0;
    mem_rdata_d = 32'h0;

    case (state_q)
      IF_RD, MEM_RD: begin
        cnt_d = cnt_inc_s;
        acc_d = acc_next_s;
        if (cnt_inc_s < len_n_q) begin
          ram_addr_d = next_addr_s;
        end else begin
          ram_addr_d = '0;
        end
        if (finish_s) begin
          state_d = IDLE;
          if (state_q == IF_RD) begin
            if_done_d = 1'b1;
            if_data_d = acc_next_s;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = acc_next_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      MEM_WR: begin
        cnt_d = cnt_inc_s;
        if (finish_s) begin
          state_d    = IDLE;
          mem_done_d = 1'b1;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = next_addr_s;
          ram_dout_d = byte_sel(wdata_q, cnt_inc_s);
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_mem_s) begin
      state_d    = mem_we_i ? MEM_WR : MEM_RD;
      cnt_d      = 3'd0;
      len_n_d    = len_to_n(mem_len_i);
      base_d     = mem_addr_i;
      wdata_d    = mem_wdata_i;
      acc_d      = 32'h0;
      ram_addr_d = mem_addr_i;
      ram_we_d   = mem_we_i;
      ram_dout_d = mem_we_i ? mem_wdata_i[7:0] : 8'h00;
    end else if (take_if_s) begin
      state_d    = IF_RD;
      cnt_d      = 3'd0;
      len_n_d    = 3'd4;
      base_d     = if_addr_i;
      wdata_d    = 32'h0;
      acc_d      = 32'h0;
      ram_addr_d = if_addr_i;
      ram_we_d   = 1'b0;
      ram_dout_d = 8'h00;
    end else begin
      ram_we_d   = ram_we_d;
    end
  end

  // State and registered outputs; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      len_n_q     <= 3'd0;
      base_q      <= '0;
      wdata_q     <= 32'h0;
      acc_q       <= 32'h0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_n_q     <= len_n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      acc_q       <= acc_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_data_o      = if_data_q;
  assign if_done_o      = if_done_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign mem_done_o     = mem_done_q;
  assign ram_addr_o     = ram_addr_q;
  assign ram_we_o       = ram_we_q;
  assign ram_dout_o     = ram_dout_q;
  assign stallreq_if_o  = if_req_i & ~if_done_q;
  assign stallreq_mem_o = mem_req_i & ~mem_done_q;

endmodule
